// File: rtl/keyboard_port_pkg.sv
// Shared io_bus device constants: status bit positions and PS/2 frame FSM encoding.
// Parity helper used by the frame receiver.
package keyboard_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_e;

   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_FRAME_ERR = 3;
   localparam int STAT_COUNT_LSB = 4;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 receive front end: input synchronizers, 11-bit frame FSM, parity/stop check
// and inactivity timeout. Emits one-cycle byte_valid or frame_err pulses.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (sampled 0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking the stop bit, then reporting the byte or an error
module ps2_frame_rx
   import keyboard_port_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   frame_state_e  state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          fall;
   logic          bit_in;

   // Third clock stage is only a history bit for falling-edge detection.
   assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
   assign bit_in = data_sync_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= 3'b111;
         data_sync_q <= 2'b11;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tmo_q       <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_q       <= tmo_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      tmo_d     = tmo_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fall && !bit_in) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
               tmo_d     = TMO_LOAD;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shift_d   = {bit_in, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (fall) begin
               parity_d = bit_in;
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               state_d = ST_IDLE;
               if (bit_in && odd_parity_ok(shift_q, parity_q)) valid_d = 1'b1;
               else                                            err_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Inactivity watchdog: silently abandons a stalled frame.
      if (state_q != ST_IDLE) begin
         if (fall) begin
            tmo_d = TMO_LOAD;
         end else if (tmo_q == '0) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
         end else begin
            tmo_d = tmo_q - 1'b1;
         end
      end
   end

   assign rx_byte    = shift_q;
   assign byte_valid = valid_q;
   assign frame_err  = err_q;

endmodule

// File: rtl/keyboard_port.sv
// PS/2 keyboard port on the shared io_bus: receive FIFO, sticky error flags,
// data/status register reads with pop-on-read.
module keyboard_port
   import keyboard_port_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire  [7:0] io_bus,
   input  logic       sel_data,
   input  logic       sel_status,
   input  logic       rnw,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       rx_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overrun_q, overrun_d;
   logic          frame_err_q, frame_err_d;

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       rx_err;
   logic       not_empty, full;
   logic       rd_data, rd_status;
   logic       push, pop;
   logic [7:0] status;
   logic [7:0] bus_out;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .frame_err (rx_err)
   );

   assign not_empty = (count_q != '0);
   assign full      = (count_q == FULL_CNT);
   assign rd_status = sel_status && rnw;
   assign rd_data   = sel_data && rnw && !sel_status;
   assign pop       = rd_data && not_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign push      = byte_valid && (!full || pop);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      if (rd_status) begin
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end
      if (byte_valid && !push) overrun_d   = 1'b1;
      if (rx_err)              frame_err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= rx_byte;
   end

   always_comb begin
      status                      = '0;
      status[STAT_NOT_EMPTY]      = not_empty;
      status[STAT_FULL]           = full;
      status[STAT_OVERRUN]        = overrun_q;
      status[STAT_FRAME_ERR]      = frame_err_q;
      status[STAT_COUNT_LSB +: 4] = 4'(count_q);
   end

   always_comb begin
      bus_out = 8'h00;
      if (rd_status)      bus_out = status;
      else if (not_empty) bus_out = fifo_mem[rd_ptr_q];
   end

   assign io_bus   = (rd_status || rd_data) ? bus_out : 8'bzzzz_zzzz;
   assign rx_ready = not_empty;

endmodule

// File: tb/tb_keyboard_port.sv
// Randomized bench for keyboard_port against a queue-based model of the receive path.
// io_bus carries weak pull-ups, so a released bus reads 0xFF.
module tb_keyboard_port;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 4096;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sel_data = 1'b0;
   logic sel_status = 1'b0;
   logic rnw = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   logic rx_ready;
   wire  [7:0] io_bus;

   for (genvar i = 0; i < 8; i++) begin : g_pull
      pullup (io_bus[i]);
   end

   keyboard_port #(
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .io_bus    (io_bus),
      .sel_data  (sel_data),
      .sel_status(sel_status),
      .rnw       (rnw),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_ready  (rx_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mq[$];
   logic       m_ov = 1'b0;
   logic       m_fe = 1'b0;
   int         half = 5;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   function automatic void model_frame(input logic [7:0] b, input logic ok);
      if (!ok)                    m_fe = 1'b1;
      else if (mq.size() == DEPTH) m_ov = 1'b1;
      else                         mq.push_back(b);
   endfunction

   function automatic logic [7:0] model_status();
      logic [7:0] s;
      s      = '0;
      s[0]   = (mq.size() != 0);
      s[1]   = (mq.size() == DEPTH);
      s[2]   = m_ov;
      s[3]   = m_fe;
      s[7:4] = 4'(mq.size());
      return s;
   endfunction

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic ps2_frame(input logic [7:0] b, input logic flip_par, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ flip_par);
      ps2_bit(stop);
      repeat (4) @(negedge clk);
      model_frame(b, !flip_par && stop);
   endtask

   task automatic bus_read(input logic sd, input logic ss, output logic [7:0] v);
      @(negedge clk);
      sel_data = sd; sel_status = ss; rnw = 1'b1;
      #1 v = io_bus;
      @(negedge clk);
      sel_data = 1'b0; sel_status = 1'b0; rnw = 1'b0;
   endtask

   task automatic check_status(input string tag);
      logic [7:0] got, exp;
      exp = model_status();
      bus_read(1'b0, 1'b1, got);
      check_val(tag, got, exp);
      m_ov = 1'b0;
      m_fe = 1'b0;
   endtask

   task automatic check_data(input string tag);
      logic [7:0] got, exp;
      exp = (mq.size() != 0) ? mq.pop_front() : 8'h00;
      bus_read(1'b1, 1'b0, got);
      check_val(tag, got, exp);
   endtask

   task automatic check_ready(input string tag);
      @(negedge clk);
      #1 check_val(tag, {7'd0, rx_ready}, {7'd0, mq.size() != 0});
   endtask

   initial begin
      logic [7:0] v, exp;
      logic [7:0] b;

      repeat (3) @(negedge clk);
      #1;
      check_val("reset_ready", {7'd0, rx_ready}, 8'h00);
      check_val("reset_bus_hiz", io_bus, 8'hFF);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_status("reset_status");

      // Single good frame
      ps2_frame(8'h1C, 1'b0, 1'b1);
      check_ready("t1_ready");
      check_status("t1_status");
      check_data("t1_data");
      check_status("t1_status_after");

      // Bad parity
      ps2_frame(8'hF0, 1'b1, 1'b1);
      check_ready("t2_ready");
      check_status("t2_status_err");
      check_status("t2_status_clr");

      // Overrun with five frames into a four-deep FIFO
      for (int i = 1; i <= 5; i++) ps2_frame(8'(i), 1'b0, 1'b1);
      check_status("t3_status_ovr");
      for (int i = 0; i < 5; i++) check_data("t3_data");

      // Push and pop on the same cycle while full
      for (int i = 0; i < 4; i++) ps2_frame(8'hA0 + 8'(i), 1'b0, 1'b1);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b_const(i));
      ps2_bit(~^8'hB4);
      ps2_data = 1'b1;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      // Two synchronizer stages plus the sampling edge, then the push edge.
      repeat (3) @(negedge clk);
      sel_data = 1'b1; rnw = 1'b1;
      #1 v = io_bus;
      exp = mq.pop_front();
      @(negedge clk);
      sel_data = 1'b0; rnw = 1'b0;
      check_val("t4_pop_data", v, exp);
      model_frame(8'hB4, 1'b1);
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
      check_status("t4_status");
      for (int i = 0; i < 4; i++) check_data("t4_drain");

      // Stall mid-frame until timeout, then a clean frame
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      repeat (TIMEOUT + 2) @(negedge clk);
      ps2_frame(8'h5A, 1'b0, 1'b1);
      check_status("t5_status");
      check_data("t5_data");
      check_status("t5_empty");

      // Writes ignored; both selects return status without popping
      ps2_frame(8'h77, 1'b0, 1'b1);
      @(negedge clk);
      sel_data = 1'b1; rnw = 1'b0;
      #1 check_val("t6_write_hiz", io_bus, 8'hFF);
      @(negedge clk);
      sel_data = 1'b0; sel_status = 1'b1;
      #1 check_val("t6_write_stat_hiz", io_bus, 8'hFF);
      @(negedge clk);
      sel_status = 1'b0;
      exp = model_status();
      bus_read(1'b1, 1'b1, v);
      check_val("t6_both_sel", v, exp);
      check_data("t6_data");

      // Randomized frames and reads
      for (int it = 0; it < 30; it++) begin
         int kind;
         half = 4 + int'($urandom_range(0, 4));
         b    = 8'($urandom);
         kind = int'($urandom_range(0, 9));
         ps2_frame(b, kind == 0, kind != 1);
         half = 5;
         case ($urandom_range(0, 3))
            0: check_status("rnd_status");
            1: check_data("rnd_data");
            2: begin check_data("rnd_data2"); check_status("rnd_status2"); end
            default: check_ready("rnd_ready");
         endcase
      end
      check_status("rnd_final_status");
      for (int i = 0; i < DEPTH + 1; i++) check_data("rnd_drain");

      // Reset in the middle of a frame with two bytes queued
      ps2_frame(8'h21, 1'b0, 1'b1);
      ps2_frame(8'h42, 1'b0, 1'b1);
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b0);
      ps2_data = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (2) @(negedge clk);
      #1 check_val("t8_ready_in_reset", {7'd0, rx_ready}, 8'h00);
      reset = 1'b0;
      mq.delete(); m_ov = 1'b0; m_fe = 1'b0;
      repeat (3) @(negedge clk);
      #1 check_val("t8_bus_hiz", io_bus, 8'hFF);
      check_status("t8_status");
      ps2_frame(8'h3C, 1'b0, 1'b1);
      check_status("t8_status_next");
      check_data("t8_data_next");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   function automatic logic b_const(input int i);
      logic [7:0] k;
      k = 8'hB4;
      return k[i];
   endfunction

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
